// File: rtl/mult_pkg.sv
// Shared types and constants for the add-shift multiplier controller.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLRA  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mult_state_t;

  localparam int MULT_WIDTH = 8;

endpackage

// File: rtl/mult_control.sv
// Sequencer for the signed add-shift multiplier: issues one-cycle datapath strobes
// for WIDTH add/shift iterations, subtracting on the last one, then holds Done.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic       M,
  output logic       Clr_Ld,
  output logic       ClrA,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign state_dbg = state_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load requests outrank Run in IDLE; the last SHIFT ends the sequence so cnt never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!ClearA_LoadB && Run) state_d = CLRA;
      end
      CLRA: begin
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates every strobe so nothing reaches the datapath while it is held.
  always_comb begin
    Clr_Ld = 1'b0;
    ClrA   = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    if (!Reset) begin
      case (state_q)
        IDLE: Clr_Ld = ClearA_LoadB;
        CLRA: begin
          ClrA = 1'b1;
          Busy = 1'b1;
        end
        ADD: begin
          Busy = 1'b1;
          if (M) begin
            if (cnt_q == LAST) Sub = 1'b1;
            else               Add = 1'b1;
          end
        end
        SHIFT: begin
          Shift = 1'b1;
          Busy  = 1'b1;
        end
        DONE: Done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
Sequencing controller for the 8x8 signed add-shift multiplier; the control end of the multiplier datapath interface.
- Consumes Run, ClearA_LoadB and the datapath's current multiplier LSB (M).
- Issues the one-cycle Clr_Ld, ClrA, Add, Sub and Shift strobes that the datapath executes.
- Performs WIDTH add/shift iterations, using Sub (two's-complement correction) on the final iteration, then holds the result until Run is released.

Parameters:
WIDTH, 8, number of multiplier bits, i.e. number of add/shift iterations.

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
Run  input  1  start request, level, synchronous and debounced at this boundary
ClearA_LoadB  input  1  clear accumulator and load B, level, synchronous and debounced
M  input  1  current multiplier LSB from datapath B register
Clr_Ld  output  1  clear A/X and load B from switches
ClrA  output  1  clear A and X at the start of a multiply
Add  output  1  A := A + S this cycle
Sub  output  1  A := A - S this cycle, final iteration only
Shift  output  1  arithmetic right shift of X:A:B this cycle
Busy  output  1  multiply in progress
Done  output  1  result valid, held until Run is low

Behaviour:
- Interface: one clock (Clk); reset (Reset) is asynchronous and active-high.
- States: IDLE, CLRA, ADD, SHIFT, DONE.
- Counter: cnt, width $clog2(WIDTH).
- Reset (any time, including mid-operation): state=IDLE, cnt=0. All outputs are 0 while Reset is high and in the first cycle after release, unless ClearA_LoadB is high in that cycle.
- IDLE:
  - ClearA_LoadB=1: Clr_Ld=1 that cycle, remain IDLE. ClearA_LoadB has priority over Run.
  - Else Run=1: go to CLRA.
  - Clr_Ld is asserted every cycle ClearA_LoadB is high in IDLE (level, not edge).
- CLRA: ClrA=1 for exactly 1 cycle, cnt:=0, go to ADD.
- ADD:
  - If M=1 and cnt!=WIDTH-1: Add=1.
  - If M=1 and cnt==WIDTH-1: Sub=1.
  - If M=0: neither is asserted.
  - Add/Sub are Mealy outputs, combinational on M within this state. Go to SHIFT.
- SHIFT:
  - Shift=1.
  - If cnt==WIDTH-1, go to DONE; else cnt:=cnt+1 and go to ADD.
  - cnt never wraps: the terminal compare ends the sequence.
- DONE:
  - Done=1, Busy=0.
  - Run=1: stay. Run=0: go to IDLE next cycle.
  - A Run held continuously therefore produces exactly one multiply.
- Busy=1 in CLRA, ADD, SHIFT.
- Mutual exclusion: at most one of Clr_Ld, ClrA, Add, Sub, Shift is high in any cycle.
- Ignored inputs:
  - ClearA_LoadB outside IDLE is ignored; there are no mid-multiply loads.
  - Run toggling during CLRA/ADD/SHIFT is ignored.
  - M is sampled only in ADD.
- Latency: Run sampled high in IDLE, then Done at cycle 2*WIDTH+2 after the sampling edge (18 for WIDTH=8).
- Strobe counts per multiply: exactly 1 ClrA and WIDTH Shift pulses. Add+Sub pulses equal the number of 1s presented on M in ADD cycles.

Decomposition:
- Shared package mult_pkg holds:
  - typedef enum logic [2:0] mult_state_t {IDLE, CLRA, ADD, SHIFT, DONE};
  - localparam MULT_WIDTH = 8, used as the WIDTH default.
- No sub-module is needed. The counter and next-state logic are inline: one always_ff for state/cnt with async reset, one always_comb for next state and outputs.

Test Plan:
1. Reset pulse with Run=1, ClearA_LoadB=1 held -> all outputs 0 during reset. After release: Clr_Ld=1 (ClearA_LoadB priority), state IDLE, no CLRA.
2. ClearA_LoadB high 1 cycle in IDLE -> Clr_Ld high exactly 1 cycle. ClearA_LoadB high during ADD -> no Clr_Ld.
3. Run=1, M model tracks B=0xFF shifting in sign (M=1 every ADD) -> ClrA 1 cycle, then Add/Shift alternating 7 times, Sub + Shift on the 8th iteration, Done at cycle 18.
4. Run=1 with B=0x00 (M=0 always) -> 0 Add, 0 Sub, 8 Shift. Run=1 with B=0x03 -> Add on iterations 0 and 1 only, no Sub.
5. Reset asserted at cycle 7 of a multiply -> outputs drop to 0 asynchronously, state IDLE. A subsequent Run performs a full 18-cycle sequence from ClrA.
6. Run held high through DONE for 20 cycles -> Done stays 1 and no new ClrA. Run low -> IDLE next cycle. Run high again -> new multiply starts.
